// File: rtl/key_conditioner_pkg.sv
// Shared constants and types for the contestant key conditioner.
// Default debounce length is 20 ms at the 50 MHz system clock.
package key_conditioner_pkg;

   localparam int N_KEYS      = 3;
   localparam int CLK_HZ      = 50_000_000;
   localparam int DEBOUNCE_MS = 20;
   localparam int DB_CYCLES   = (CLK_HZ / 1000) * DEBOUNCE_MS;
   localparam int ID_W        = 2;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_e;

endpackage : key_conditioner_pkg

// File: rtl/key_conditioner_debounce.sv
// One key channel: 2-flop synchroniser, debounce counter, clean level and press pulse.
// The raw input is active-low; the level and the pulse are active-high.
module key_conditioner_debounce
   import key_conditioner_pkg::*;
#(
   parameter int DB_CYCLES_P = DB_CYCLES
) (
   input  logic clock_i,
   input  logic reset_i,
   input  logic raw_key_n_i,
   output logic level_o,
   output logic press_o
);

   localparam int                CNT_W   = $clog2(DB_CYCLES_P);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DB_CYCLES_P - 1);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             pressed;

   assign pressed = ~sync2_q;

   // Any sample agreeing with the current level restarts the stability count.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      if (pressed == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         level_d = pressed;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      press_d = level_d & ~level_q;
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= raw_key_n_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule : key_conditioner_debounce

// File: rtl/key_conditioner.sv
// Debounced contestant keys plus a first-press lock held until the host clears the round.
// On simultaneous presses the lowest key index wins.
module key_conditioner
   import key_conditioner_pkg::*;
#(
   parameter int N_KEYS_P    = N_KEYS,
   parameter int DB_CYCLES_P = DB_CYCLES
) (
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic [N_KEYS_P-1:0] raw_key_n_i,
   input  logic                clear_i,
   output logic [N_KEYS_P-1:0] key_level_o,
   output logic [N_KEYS_P-1:0] key_press_o,
   output logic                first_valid_o,
   output logic [ID_W-1:0]     first_id_o
);

   lock_state_e     state_q, state_d;
   logic            valid_q, valid_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [ID_W-1:0] hit_id;

   for (genvar gi = 0; gi < N_KEYS_P; gi++) begin : g_key
      key_conditioner_debounce #(
         .DB_CYCLES_P (DB_CYCLES_P)
      ) u_debounce (
         .clock_i     (clock_i),
         .reset_i     (reset_i),
         .raw_key_n_i (raw_key_n_i[gi]),
         .level_o     (key_level_o[gi]),
         .press_o     (key_press_o[gi])
      );
   end

   // Scan downwards so the lowest pressed index is the one left standing.
   always_comb begin
      hit_id = '0;
      for (int i = N_KEYS_P - 1; i >= 0; i--) begin
         if (key_press_o[i]) begin
            hit_id = ID_W'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      id_d    = id_q;
      case (state_q)
         ST_IDLE: begin
            if ((|key_press_o) && !clear_i) begin
               state_d = ST_LOCKED;
               valid_d = 1'b1;
               id_d    = hit_id;
            end
         end
         ST_LOCKED: begin
            if (clear_i) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               id_d    = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            id_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_i) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         id_q    <= id_d;
      end
   end

   assign first_valid_o = valid_q;
   assign first_id_o    = id_q;

endmodule : key_conditioner

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with a short debounce window.
module tb_key_conditioner;

   localparam int N  = 3;
   localparam int DB = 4;
   localparam int HL = DB + 2;

   typedef struct packed {
      logic [N-1:0] level;
      logic [N-1:0] press;
      logic         valid;
      logic [1:0]   id;
   } exp_t;

   logic         clock = 1'b0;
   logic         reset_n = 1'b0;
   logic [N-1:0] raw_key_n = '1;
   logic         clear = 1'b0;
   logic [N-1:0] key_level, key_press;
   logic         first_valid;
   logic [1:0]   first_id;

   int checks = 0;
   int errors = 0;

   exp_t sb_q[$];

   // Reference model: raw-sample history per key, lock state
   logic         hist [N][HL];
   logic [N-1:0] m_level = '0, m_press = '0;
   logic         m_locked = 1'b0, m_valid = 1'b0;
   logic [1:0]   m_id = '0;

   always #5 clock = ~clock;

   key_conditioner #(
      .N_KEYS_P    (N),
      .DB_CYCLES_P (DB)
   ) dut (
      .clock_i       (clock),
      .reset_i       (reset_n),
      .raw_key_n_i   (raw_key_n),
      .clear_i       (clear),
      .key_level_o   (key_level),
      .key_press_o   (key_press),
      .first_valid_o (first_valid),
      .first_id_o    (first_id)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model one clock edge. The level flips when the last DB synchronised samples
   // (raw delayed by two edges) all disagree with it.
   task automatic model_edge(input logic [N-1:0] raw, input logic clr, input logic rst_n);
      exp_t e;
      logic [N-1:0] new_press;
      if (!rst_n) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < HL; j++) hist[i][j] = 1'b1;
         m_level = '0; m_press = '0; m_locked = 1'b0; m_valid = 1'b0; m_id = '0;
      end else begin
         if (!m_locked && (m_press != '0) && !clr) begin
            m_locked = 1'b1;
            m_valid  = 1'b1;
            m_id     = m_press[0] ? 2'd0 : (m_press[1] ? 2'd1 : 2'd2);
         end else if (m_locked && clr) begin
            m_locked = 1'b0;
            m_valid  = 1'b0;
            m_id     = 2'd0;
         end
         new_press = '0;
         for (int i = 0; i < N; i++) begin
            logic all_diff;
            for (int j = HL - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
            hist[i][0] = raw[i];
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++)
               if (!hist[i][2+j] == m_level[i]) all_diff = 1'b0;
            if (all_diff) begin
               new_press[i] = ~m_level[i];
               m_level[i]   = ~m_level[i];
            end
         end
         m_press = new_press;
      end
      e.level = m_level; e.press = m_press; e.valid = m_valid; e.id = m_id;
      sb_q.push_back(e);
   endtask

   task automatic step(input logic [N-1:0] raw, input logic clr, input logic rst_n);
      exp_t e;
      raw_key_n = raw;
      clear     = clr;
      reset_n   = rst_n;
      @(posedge clock);
      model_edge(raw, clr, rst_n);
      #1;
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check("key_level",   32'(key_level),   32'(e.level));
         check("key_press",   32'(key_press),   32'(e.press));
         check("first_valid", 32'(first_valid), 32'(e.valid));
         check("first_id",    32'(first_id),    32'(e.id));
      end
      clear = 1'b0;
   endtask

   task automatic run(input logic [N-1:0] raw, input int n);
      for (int i = 0; i < n; i++) step(raw, 1'b0, 1'b1);
   endtask

   initial begin
      // Reset with key 1 held; everything reads zero and stays so until debounced
      step(3'b101, 1'b0, 1'b0);
      step(3'b101, 1'b0, 1'b0);
      check("rst_level", 32'(key_level), 32'd0);
      check("rst_valid", 32'(first_valid), 32'd0);
      run(3'b101, 10);
      check("k1_id", 32'(first_id), 32'd1);
      run(3'b111, 8);
      step(3'b111, 1'b1, 1'b1);
      check("clr_valid", 32'(first_valid), 32'd0);

      // Single press of key 1 with explicit latency checks
      run(3'b101, 5);
      check("k1_lat_before", 32'(key_level[1]), 32'd0);
      run(3'b101, 1);
      check("k1_lat_after", 32'(key_level[1]), 32'd1);
      check("k1_pulse", 32'(key_press), 32'b010);
      run(3'b101, 1);
      check("k1_lock", {30'd0, first_valid, 1'b0} | 32'(first_id), 32'd3);
      run(3'b101, 3);
      run(3'b111, 8);
      step(3'b111, 1'b1, 1'b1);

      // Short pulse on key 0 is rejected; bounce then settles to one press
      run(3'b110, 3);
      run(3'b111, 8);
      check("short_valid", 32'(first_valid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         logic [7:0] pat;
         pat = 8'b10100000;
         step({2'b11, pat[7-i]}, 1'b0, 1'b1);
      end
      run(3'b110, 4);
      check("bounce_id", {30'd0, first_valid, 1'b0} | 32'(first_id), 32'd2);
      run(3'b111, 8);
      step(3'b111, 1'b1, 1'b1);

      // Keys 0 and 2 together -> 0 wins; key 1 later is ignored while locked
      run(3'b010, 8);
      check("tie_id", 32'(first_id), 32'd0);
      run(3'b000, 8);
      check("locked_id", 32'(first_id), 32'd0);
      check("locked_valid", 32'(first_valid), 32'd1);
      run(3'b111, 8);

      // Clear lands on key 2's press cycle: press discarded, held key never relocks
      for (int i = 0; i < 10; i++) step(3'b011, m_press[2], 1'b1);
      run(3'b011, 6);
      check("clr_press_valid", 32'(first_valid), 32'd0);
      run(3'b111, 8);
      run(3'b011, 8);
      check("repress_id", 32'(first_id), 32'd2);
      run(3'b111, 8);
      step(3'b111, 1'b1, 1'b1);

      // Reset mid-debounce on key 0, then full latency from the new samples
      run(3'b110, 4);
      step(3'b110, 1'b0, 1'b0);
      check("mid_rst_level", 32'(key_level), 32'd0);
      run(3'b110, 5);
      check("post_rst_before", 32'(key_level[0]), 32'd0);
      run(3'b110, 1);
      check("post_rst_after", 32'(key_level[0]), 32'd1);
      run(3'b110, 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_key_conditioner
